cbadder_seq_ctrl: RTL and testbench
===================================

Name: cbadder_seq_ctrl

Overview:
- Sequencer that performs a wide add (NIBBLES×4 bits) by time-multiplexing one external 4-bit adder slice (cbadder-class: carry-bypass, ripple or product-machine variant).
- Selects operand nibble pairs LSB-first, forwards the registered carry into each slice, and collects the sum nibbles.
- Reports the result through a start/busy/done handshake.
- Sits between a host/test driver and the shared 4-bit adder. The adder is purely combinational and external to this block.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (≥1); operand width W = 4*NIBBLES.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A, captured on accepted start.
- op_b  in  W  operand B, captured on accepted start.
- op_cin  in  1  carry-in, captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and cout are valid.
- result  out  W  sum; held until the next accepted start.
- cout  out  1  final carry-out; held with result.
- add_a  out  4  nibble of A to the adder slice.
- add_b  out  4  nibble of B to the adder slice.
- add_cin  out  1  carry to the adder slice.
- add_sum  in  4  adder slice sum.
- add_cout  in  1  adder slice carry-out.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; idx=0; carry=0; operand registers=0; busy=0; done=0; result=0; cout=0.
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start=1. At that edge: a_reg=op_a, b_reg=op_b, carry=op_cin, idx=0, result=0, cout=0.
  - RUN: each clock edge writes result[idx*4+:4]=add_sum and sets carry=add_cout.
    - If idx==NIBBLES-1: cout=add_cout and go to DONE.
    - Otherwise idx=idx+1.
  - DONE→IDLE unconditionally after one cycle. done=1 only in DONE.
- Adder drive (combinational from registers, all states):
  - add_a=a_reg[idx*4+:4], add_b=b_reg[idx*4+:4], add_cin=carry.
  - In IDLE these present the stale registers. Consumers must not rely on them.
- Latency:
  - Start accepted at edge E0. Slice k is captured at edge E(k+1).
  - done is high in the cycle following edge E(NIBBLES).
  - Throughput: one operation per NIBBLES+2 cycles.
- start while busy=1, including in DONE: ignored, with no effect on operands or result.
- start and done in the same cycle: start is ignored; the host re-asserts it in IDLE.
- op_a, op_b and op_cin may change freely after acceptance.
- Arithmetic: {cout,result} = op_a + op_b + op_cin, computed modulo 2^(W+1). Carry chains across slice boundaries exactly as in a single wide adder.
- idx width = max(1, clog2(NIBBLES)). No wrap-around occurs beyond NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle, and the block degenerates to a registered 4-bit add.
- Reset mid-RUN: the operation is aborted, result/cout are cleared, and done never pulses for the aborted operation. The first start after reset release behaves normally.

Test Plan:
1. NIBBLES=4: op_a=0x1234, op_b=0x4321, op_cin=0, start pulse → done exactly 4 cycles after the start edge; result=0x5555, cout=0; busy high for 5 cycles.
2. op_a=0xFFFF, op_b=0x0001, op_cin=0 → result=0x0000, cout=1. Bench checks add_cin=1 on slices 1–3 (full carry propagation across slices).
3. op_a=0xFFFF, op_b=0x0000, op_cin=1 → result=0x0000, cout=1. Then op_a=0x8000, op_b=0x8000, op_cin=0 → result=0x0000, cout=1.
4. Start 0x00FF+0x0001, then re-assert start with 0xAAAA+0x5555 during RUN and during DONE → result=0x0100, cout=0. The second operation is accepted only after return to IDLE and yields 0xFFFF, cout=0.
5. Assert rst_n=0 asynchronously mid-clock, two cycles into RUN → busy/done/result/cout go to 0 immediately; no done pulse. After release, 0x0001+0x0001 yields 0x0002.
6. NIBBLES=1 with a behavioural 4-bit adder model: exhaustive a=0..15, b=0..15, cin=0..1 (512 ops) → {cout,result}==a+b+cin and done 1 cycle after each start.

Source files
------------

// File: rtl/cbadder_seq_ctrl.sv
// cbadder_seq_ctrl
// Performs a W = 4*NIBBLES bit add by time-multiplexing one external,
// purely combinational 4-bit adder slice. Operand nibbles are presented
// LSB-first. The carry out of each slice is registered and fed into the
// next slice, so the carry chain matches a single wide adder.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   start               request, sampled only while idle
//   op_a, op_b, op_cin  operands, captured when start is accepted
//   busy                high while an operation is running or completing
//   done                one-cycle pulse; result/cout are valid
//   result, cout        sum and final carry, held until the next accepted start
//   add_a, add_b        operand nibbles driven to the external adder slice
//   add_cin             registered carry driven to the adder slice
//   add_sum, add_cout   sum and carry returned by the adder slice
//
// state   | meaning
// IDLE    | waiting for start; adder drive shows stale registers
// RUN     | one slice captured per clock, LSB nibble first
// DONE    | result/cout valid, done pulses for one cycle
module cbadder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    carry_d  = op_cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    // idx is left at the last slice; the next accepted start clears it
                    cout_d  = add_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; the host retries in IDLE
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign add_a   = a_q[{idx_q, 2'b00} +: 4];
    assign add_b   = b_q[{idx_q, 2'b00} +: 4];
    assign add_cin = carry_q;

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_cbadder_seq_ctrl.sv
// Testbench for cbadder_seq_ctrl: a 4-nibble instance and a 1-nibble
// instance, each wired to a behavioural 4-bit adder slice. Drivers push
// the expected sum and done cycle into a queue; monitors pop and compare
// whenever done is seen.
module tb_cbadder_seq_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] sum;
        int          cyc;
    } op4_t;

    typedef struct {
        logic [4:0] sum;
        int         cyc;
    } op1_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // 4-nibble instance
    logic        start4 = 1'b0;
    logic [15:0] op_a4 = '0, op_b4 = '0;
    logic        op_cin4 = 1'b0;
    logic        busy4, done4, cout4, add_cin4, add_cout4;
    logic [15:0] result4;
    logic [3:0]  add_a4, add_b4, add_sum4;

    // 1-nibble instance
    logic        start1 = 1'b0;
    logic [3:0]  op_a1 = '0, op_b1 = '0;
    logic        op_cin1 = 1'b0;
    logic        busy1, done1, cout1, add_cin1, add_cout1;
    logic [3:0]  result1;
    logic [3:0]  add_a1, add_b1, add_sum1;

    op4_t q4[$];
    op1_t q1[$];
    int   busy_run4 = 0;
    int   busy_run1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural adder slices
    assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);
    assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

    cbadder_seq_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .op_a(op_a4), .op_b(op_b4), .op_cin(op_cin4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    cbadder_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        op4_t it;
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy4) chk("idle_wait4", 32'(busy4), 32'd0);
        op_a4   = a;
        op_b4   = b;
        op_cin4 = cin;
        start4  = 1'b1;
        it.a    = a;
        it.b    = b;
        it.cin  = cin;
        it.sum  = 17'(a) + 17'(b) + 17'(cin);
        it.cyc  = cyc + 1 + 4;
        q4.push_back(it);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        op1_t it;
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy1) chk("idle_wait1", 32'(busy1), 32'd0);
        op_a1   = a;
        op_b1   = b;
        op_cin1 = cin;
        start1  = 1'b1;
        it.sum  = 5'(a) + 5'(b) + 5'(cin);
        it.cyc  = cyc + 1 + 1;
        q1.push_back(it);
        @(negedge clk);
        start1 = 1'b0;
        // scramble inputs after acceptance; must not matter
        op_a1 = 4'($urandom);
        op_b1 = 4'($urandom);
    endtask

    // monitor for the 4-nibble instance
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run4 = 0;
        end else begin
            if (busy4 && !done4 && q4.size() > 0 && busy_run4 < 4) begin
                int k;
                logic [31:0] mask, s;
                k    = busy_run4;
                mask = (32'd1 << (4 * k)) - 32'd1;
                s    = (32'(q4[0].a) & mask) + (32'(q4[0].b) & mask) + 32'(q4[0].cin);
                chk($sformatf("slice%0d_add_a", k), 32'(add_a4), 32'(q4[0].a[4*k +: 4]));
                chk($sformatf("slice%0d_add_b", k), 32'(add_b4), 32'(q4[0].b[4*k +: 4]));
                chk($sformatf("slice%0d_add_cin", k), 32'(add_cin4), 32'(s[4*k]));
            end
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_done4", 32'(done4), 32'd0);
                end else begin
                    op4_t it;
                    it = q4.pop_front();
                    chk("result4", 32'(result4), 32'(it.sum[15:0]));
                    chk("cout4", 32'(cout4), 32'(it.sum[16]));
                    chk("done_cycle4", 32'(cyc), 32'(it.cyc));
                end
            end
            if (busy4) begin
                busy_run4++;
            end else if (busy_run4 != 0) begin
                chk("busy_len4", 32'(busy_run4), 32'd5);
                busy_run4 = 0;
            end
        end
    end

    // monitor for the 1-nibble instance
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run1 = 0;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done1", 32'(done1), 32'd0);
                end else begin
                    op1_t it;
                    it = q1.pop_front();
                    chk("result1", 32'(result1), 32'(it.sum[3:0]));
                    chk("cout1", 32'(cout1), 32'(it.sum[4]));
                    chk("done_cycle1", 32'(cyc), 32'(it.cyc));
                end
            end
            if (busy1) begin
                busy_run1++;
            end else if (busy_run1 != 0) begin
                chk("busy_len1", 32'(busy_run1), 32'd2);
                busy_run1 = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #12;
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_result4", 32'(result4), 32'd0);
        chk("rst_cout4", 32'(cout4), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_result1", 32'(result1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        do_op4(16'h1234, 16'h4321, 1'b0);
        do_op4(16'hFFFF, 16'h0001, 1'b0);
        do_op4(16'hFFFF, 16'h0000, 1'b1);
        do_op4(16'h8000, 16'h8000, 1'b0);

        // start held through RUN and DONE is ignored
        do_op4(16'h00FF, 16'h0001, 1'b0);
        op_a4   = 16'hAAAA;
        op_b4   = 16'h5555;
        op_cin4 = 1'b1;
        start4  = 1'b1;
        repeat (5) @(negedge clk);
        start4 = 1'b0;
        do_op4(16'hAAAA, 16'h5555, 1'b0);

        // asynchronous reset two cycles into RUN
        do_op4(16'h1111, 16'h2222, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q4.delete();
        #1;
        chk("abort_busy4", 32'(busy4), 32'd0);
        chk("abort_done4", 32'(done4), 32'd0);
        chk("abort_result4", 32'(result4), 32'd0);
        chk("abort_cout4", 32'(cout4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_op4(16'h0001, 16'h0001, 1'b0);

        // random operations
        for (int i = 0; i < 40; i++) begin
            do_op4(16'($urandom), 16'($urandom), 1'($urandom));
        end

        // exhaustive single-nibble instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op1(4'(a), 4'(b), 1'(c));
                end
            end
        end

        n = 0;
        while ((q4.size() != 0 || q1.size() != 0 || busy4 || busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q4", 32'(q4.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
